des_key_schedule: RTL
=====================

Name: des_key_schedule

Overview:
- Sequential DES subkey generator.
- Takes a 64-bit key and emits the sixteen 48-bit round subkeys, one per accepted transfer, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Sits directly upstream of the round datapath: each subkey is XORed with the expanded 48-bit R half, and the result feeds des_sboxes block_i.
- Uses a valid/ready handshake so the round engine can stall.

Parameters:
- none (DES is fixed: 16 rounds, 28-bit C/D halves, 48-bit subkeys)

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  synchronous active-low reset
- start_i  input  1  begin a new schedule; accepted only when busy_o=0
- key_i  input  64  DES key; key_i[63] = DES bit 1; parity bits (DES bits 8,16,..,64) ignored
- decrypt_i  input  1  sampled with start_i; 0 = K1..K16, 1 = K16..K1
- subkey_o  output  48  current subkey; subkey_o[47] = PC-2 output bit 1
- subkey_valid_o  output  1  subkey_o is valid
- subkey_ready_i  input  1  consumer accepts subkey_o this cycle
- round_o  output  4  transfer index 0..15 of the subkey currently presented
- busy_o  output  1  schedule in progress
- done_o  output  1  one-cycle pulse after the 16th transfer

Behaviour:
- Reset (rst_ni=0 at clk_i edge; synchronous, active-low): C=0, D=0, round=0, state IDLE. Output values:
  - subkey_valid_o=0, busy_o=0, done_o=0, round_o=0
  - subkey_o=0 (PC-2 of all-zero C/D)
- Reset takes priority over all other inputs. Reset mid-schedule aborts it with no done_o.
- State: 28-bit registers C and D, 4-bit round counter, 1-bit mode, states IDLE and RUN.
- subkey_o = PC-2({C,D}). It is combinational from registers only, with no input-to-output path.
- Shift table, 0-based index: SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- IDLE, start_i=1:
  - {C0,D0} = PC-1(key_i).
  - Encrypt: C,D <= rotl1(C0),rotl1(D0), which gives K1.
  - Decrypt: C,D <= C0,D0 (equals K16, because the total left rotation is 28).
  - round <= 0, mode <= decrypt_i, go to RUN.
  - The subkey is presented on the next cycle, so latency from start_i to the first subkey_valid_o is 1 cycle.
- IDLE, start_i=0: hold state. C/D retain their last value and subkey_o holds, but subkey_valid_o=0.
- RUN:
  - subkey_valid_o=1 and busy_o=1.
  - Transfer occurs when subkey_valid_o & subkey_ready_i are both high.
  - No transfer: hold C, D and round. subkey_o and round_o are stable while stalled.
  - Transfer with round<15:
    - round <= round+1.
    - Encrypt: C,D <= rotl(C,D, SHIFT[round+1]).
    - Decrypt: C,D <= rotr(C,D, SHIFT[15-round]).
  - Transfer with round==15: go to IDLE and round <= 0. done_o=1 on the following cycle only.
  - start_i is ignored in RUN.
- Back-to-back: start_i is accepted in the same cycle that done_o=1, because the block is already IDLE.
- Maximum throughput: one subkey per cycle with subkey_ready_i held high. Start to done_o is 17 cycles.
- Rotations act independently on each 28-bit half. The MSB of each half is DES bit 1 of that half.
- PC-1 and PC-2 are the FIPS 46-3 tables. Bit numbering is MSB-first, as on key_i.

Test Plan:
- Encrypt, key 0x133457799BBCDFF1, ready=1:
  - First valid subkey 0x1B02EFFC7072 with round_o=0.
  - round_o=1: 0x79AED9DBC9E5.
  - round_o=15: 0xCB3D8B0E17F5.
  - done_o pulses exactly one cycle after the 16th transfer.
- Decrypt, same key, ready=1:
  - round_o=0 gives 0xCB3D8B0E17F5.
  - round_o=15 gives 0x1B02EFFC7072.
  - All 16 subkeys equal the encrypt sequence reversed, checked against the reference model.
- Stall: drive ready=0 for 5 cycles at round_o=3.
  - subkey_o, round_o and valid are held constant.
  - No skipped or duplicated subkey; the full sequence still matches.
- Ignored start: pulse start_i with a different key at round_o=7.
  - The sequence is unaffected.
  - A second start in the done_o cycle begins a new schedule; the first subkey appears on the next cycle.
- Reset mid-run: assert rst_ni=0 for 1 cycle at round_o=9.
  - Next cycle: valid=0, busy=0, round_o=0, subkey_o=0.
  - No done_o.
  - Reset asserted without a clock edge has no effect, since it is synchronous.
- Parity independence: keys 0x133457799BBCDFF1 and 0x123456789ABCDEF0 differ only in the parity bits (DES bits 8,16,..,64), so both produce identical subkeys. Check with randomised ready against the reference model for 100 random keys in both modes.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES round-subkey generator: loads PC-1 of the key, then presents K1..K16 (or K16..K1)
// one per valid/ready transfer by rotating the 28-bit C/D halves.
module des_key_schedule (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  output logic [47:0] subkey_o,
  output logic        subkey_valid_o,
  input  logic        subkey_ready_i,
  output logic [3:0]  round_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Bit i set where the per-round shift amount is 2 (shifts of 1 at rounds 0, 1, 8, 15).
  localparam logic [15:0] SHIFT_TWO = 16'b0111_1110_1111_1100;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [27:0] c_q, d_q, c_d, d_d;
  logic [3:0]  round_q, round_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic [55:0] cd0;
  logic        shift_two;

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = key[64-PC1_TBL[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2_TBL[j]];
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    round_d   = round_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    cd0       = pc1(key_i);
    shift_two = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          // Decrypt starts at the unrotated halves: the full 28-bit rotation of K16 is identity.
          if (decrypt_i) begin
            c_d = cd0[55:28];
            d_d = cd0[27:0];
          end else begin
            c_d = rotl28(cd0[55:28], 1'b0);
            d_d = rotl28(cd0[27:0], 1'b0);
          end
          round_d = 4'd0;
          mode_d  = decrypt_i;
          state_d = RUN;
        end
      end
      RUN: begin
        if (subkey_ready_i) begin
          if (round_q == 4'd15) begin
            state_d = IDLE;
            round_d = 4'd0;
            done_d  = 1'b1;
          end else begin
            round_d = round_q + 4'd1;
            if (mode_q) begin
              shift_two = SHIFT_TWO[4'd15 - round_q];
              c_d = rotr28(c_q, shift_two);
              d_d = rotr28(d_q, shift_two);
            end else begin
              shift_two = SHIFT_TWO[round_q + 4'd1];
              c_d = rotl28(c_q, shift_two);
              d_d = rotl28(d_q, shift_two);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign subkey_o       = pc2({c_q, d_q});
  assign subkey_valid_o = (state_q == RUN);
  assign busy_o         = (state_q == RUN);
  assign round_o        = round_q;
  assign done_o         = done_q;

endmodule
